// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI message scheduler: message-type codes,
// long-message header code and the scheduler state encoding.
package spi_pkg;
   localparam logic [2:0] NO_BY      = 3'b000;
   localparam logic [2:0] ONE_BY     = 3'b001;
   localparam logic [2:0] STD_TWO_BY = 3'b010;
   localparam logic [2:0] THREE_BY   = 3'b011;
   localparam logic [2:0] SIX_BY     = 3'b110;
   localparam logic [2:0] LONG       = 3'b111;
   localparam logic [3:0] LONG_HDR   = 4'hF;
   localparam logic [3:0] MAX_LONG   = 4'd6;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_BUSY, WAIT_SENT, DONE} sched_state_e;

   function automatic logic long_len_ok(input logic [3:0] len);
      return (len != 4'd0) && (len <= MAX_LONG);
   endfunction
endpackage

// File: rtl/spi_msg_sched_rr_arbiter.sv
// Combinational round-robin picker: lowest set mask bit at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] mask,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    gnt,
   output logic             vld
);
   int j;

   // Walk from the farthest offset down so the nearest hit is written last.
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      j   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (mask[j[IW-1:0]]) begin
            gnt = IW'(j);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spi_msg_sched.sv
// Arbitrates requesters onto the SPI slave engine's send channel, retries sends
// pre-empted by master receives, and arms the engine for long incoming messages.
module spi_msg_sched
   import spi_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TMO_W = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_REQ-1:0]    req,
   input  logic [3*N_REQ-1:0]  req_type,
   input  logic [4*N_REQ-1:0]  req_len,
   input  logic [48*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]    done,
   output logic [N_REQ-1:0]    err,
   output logic                spi_send_trigger,
   output logic [47:0]         spi_output_data,
   output logic [2:0]          spi_msg_type,
   output logic [3:0]          spi_byte_count,
   output logic                spi_long_coming,
   input  logic                spi_busy,
   input  logic                spi_sent,
   input  logic                spi_received,
   input  logic [47:0]         spi_received_data,
   output logic                rx_valid,
   output logic [47:0]         rx_data,
   output logic                rx_long
);
   localparam int IW = $clog2(N_REQ);
   // Leaving at this count makes the error appear 2^TMO_W-1 cycles after entry.
   localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

   sched_state_e     state, state_nxt;
   logic [IW-1:0]    rr_ptr, rr_ptr_nxt, gnt_idx, pick;
   logic             pick_vld, grant, arm_now;
   logic [TMO_W-1:0] cnt, cnt_nxt;
   logic [3:0]       len_q, long_len;
   logic             long_armed;
   logic [N_REQ-1:0] bad, cand, err_nxt;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   assign arm_now = spi_received && !long_armed &&
                    (spi_received_data[15:12] == LONG_HDR) &&
                    long_len_ok(spi_received_data[3:0]);

   // A long request waits while arming is pending; malformed ones are still
   // candidates so the arbiter can pick and reject them.
   for (genvar i = 0; i < N_REQ; i++) begin : g_req
      logic [2:0] t;
      logic [3:0] l;
      assign t       = req_type[3*i +: 3];
      assign l       = req_len[4*i +: 4];
      assign bad[i]  = (t == NO_BY) || ((t == LONG) && !long_len_ok(l));
      assign cand[i] = req[i] && !err[i] &&
                       (bad[i] || !((t == LONG) && (long_armed || arm_now)));
   end

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .mask (cand),
      .ptr  (rr_ptr),
      .gnt  (pick),
      .vld  (pick_vld)
   );

   always_comb begin
      state_nxt        = state;
      rr_ptr_nxt       = rr_ptr;
      cnt_nxt          = '0;
      err_nxt          = '0;
      grant            = 1'b0;
      spi_send_trigger = 1'b0;
      done             = '0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               if (bad[pick]) begin
                  err_nxt[pick] = 1'b1;
                  rr_ptr_nxt    = ptr_inc(pick);
               end else begin
                  grant     = 1'b1;
                  state_nxt = TRIG;
               end
            end
         end
         TRIG: begin
            if (!spi_busy) begin
               spi_send_trigger = 1'b1;
               state_nxt        = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (spi_busy) state_nxt = WAIT_SENT;
            else if (cnt != '0) state_nxt = TRIG;
            else cnt_nxt = cnt + 1'b1;
         end
         WAIT_SENT: begin
            if (spi_sent) state_nxt = DONE;
            else if (spi_received) state_nxt = TRIG;
            else if (cnt == TMO_LAST) begin
               err_nxt[gnt_idx] = 1'b1;
               state_nxt        = IDLE;
            end else cnt_nxt = cnt + 1'b1;
         end
         DONE: begin
            done[gnt_idx] = 1'b1;
            rr_ptr_nxt    = ptr_inc(gnt_idx);
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         cnt             <= '0;
         err             <= '0;
         gnt_idx         <= '0;
         spi_output_data <= '0;
         spi_msg_type    <= '0;
         len_q           <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         cnt    <= cnt_nxt;
         err    <= err_nxt;
         if (grant) begin
            gnt_idx         <= pick;
            spi_output_data <= req_data[48*pick +: 48];
            spi_msg_type    <= req_type[3*pick +: 3];
            len_q           <= (req_type[3*pick +: 3] == LONG) ? req_len[4*pick +: 4] : 4'd0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_long    <= 1'b0;
         long_armed <= 1'b0;
         long_len   <= '0;
      end else begin
         rx_valid <= spi_received;
         if (spi_received) begin
            rx_data <= spi_received_data;
            rx_long <= long_armed;
         end
         if (arm_now) begin
            long_armed <= 1'b1;
            long_len   <= spi_received_data[3:0];
         end else if (spi_received) begin
            long_armed <= 1'b0;
         end
      end
   end

   assign spi_long_coming = long_armed;
   assign spi_byte_count  = long_armed ? long_len : ((state == IDLE) ? 4'd0 : len_q);
endmodule

// File: tb/tb_spi_msg_sched.sv
// Directed bench for spi_msg_sched with a receive-path model and a transfer
// hold/retry monitor checked every cycle alongside hand-computed expectations.
module tb_spi_msg_sched;
   localparam int N = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic [N-1:0]    req = '0;
   logic [3*N-1:0]  req_type = '0;
   logic [4*N-1:0]  req_len = '0;
   logic [48*N-1:0] req_data = '0;
   logic [N-1:0]    done, err;
   logic            spi_send_trigger, spi_long_coming, rx_valid, rx_long;
   logic [47:0]     spi_output_data, rx_data;
   logic [2:0]      spi_msg_type;
   logic [3:0]      spi_byte_count;
   logic            spi_busy = 1'b0, spi_sent = 1'b0, spi_received = 1'b0;
   logic [47:0]     spi_received_data = '0;

   spi_msg_sched #(.N_REQ(N), .TMO_W(4)) dut (
      .CLK(CLK), .RST(RST), .req(req), .req_type(req_type), .req_len(req_len),
      .req_data(req_data), .done(done), .err(err),
      .spi_send_trigger(spi_send_trigger), .spi_output_data(spi_output_data),
      .spi_msg_type(spi_msg_type), .spi_byte_count(spi_byte_count),
      .spi_long_coming(spi_long_coming), .spi_busy(spi_busy), .spi_sent(spi_sent),
      .spi_received(spi_received), .spi_received_data(spi_received_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_long(rx_long)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0, n_errors = 0;
   int trig_cnt = 0, n_done = 0, n_errp = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Receive-path model: what the engine-facing arming and rx outputs must be.
   logic        m_armed, m_rxv, m_rxl;
   logic [3:0]  m_len;
   logic [47:0] m_rxd;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_armed = 0; m_rxv = 0; m_rxl = 0; m_len = 0; m_rxd = 0;
      end else begin
         m_rxv = spi_received;
         if (spi_received) begin
            m_rxd = spi_received_data;
            m_rxl = m_armed;
            if (m_armed) m_armed = 0;
            else if (spi_received_data[15:12] == 4'hF && spi_received_data[3:0] >= 1 &&
                     spi_received_data[3:0] <= 6) begin
               m_armed = 1;
               m_len   = spi_received_data[3:0];
            end
         end
      end
   end

   // Per-cycle compare: rx path, pulse shape, payload held from first trigger to done/err.
   logic        inflight = 0;
   logic [47:0] held_data;
   logic [2:0]  held_type;
   always @(negedge CLK) begin
      if (RST) inflight = 0;
      else begin
         check("long_coming", spi_long_coming, m_armed);
         if (m_armed) check("byte_count_armed", spi_byte_count, m_len);
         check("rx_valid", rx_valid, m_rxv);
         if (m_rxv) begin
            check("rx_data", rx_data, m_rxd);
            check("rx_long", rx_long, m_rxl);
         end
         check("done_onehot", $onehot0(done), 1);
         check("err_onehot", $onehot0(err), 1);
         if (spi_send_trigger) begin
            trig_cnt++;
            if (inflight) check("retry_data", spi_output_data, held_data);
            else begin
               inflight  = 1;
               held_data = spi_output_data;
               held_type = spi_msg_type;
            end
         end else if (inflight) begin
            check("hold_data", spi_output_data, held_data);
            check("hold_type", spi_msg_type, held_type);
         end
         if (done != 0 || err != 0) inflight = 0;
         if (done != 0) n_done++;
         if (err != 0) n_errp++;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic outs_nonzero();
      return |{done, err, spi_send_trigger, spi_output_data, spi_msg_type, spi_byte_count,
               spi_long_coming, rx_valid, rx_data, rx_long};
   endfunction

   task automatic reset_dut();
      RST = 1; req = '0; req_type = '0; req_len = '0; req_data = '0;
      spi_busy = 0; spi_sent = 0; spi_received = 0; spi_received_data = '0;
      #1;
      check("reset_outputs", outs_nonzero(), 0);
      tick(); tick();
      RST = 0;
      tick();
   endtask

   task automatic set_req(input int i, input logic [2:0] t, input logic [3:0] l,
                          input logic [47:0] d);
      req_type[3*i +: 3] = t;
      req_len[4*i +: 4]  = l;
      req_data[48*i +: 48] = d;
      req[i] = 1'b1;
   endtask

   task automatic wait_trig(input string nm, output int lat);
      lat = 0;
      while (!spi_send_trigger && lat < 40) begin
         tick();
         lat++;
      end
      if (!spi_send_trigger) check({nm, "_trig_timeout"}, 0, 1);
   endtask

   // Engine accepts the trigger, goes busy, and reports sent two cycles later.
   task automatic serve(input int idx, input string nm);
      tick(); spi_busy = 1;
      tick(); tick();
      spi_sent = 1; spi_busy = 0;
      tick(); spi_sent = 0;
      check({nm, "_done"}, done, 64'(1) << idx);
   endtask

   function automatic logic [47:0] pay(input int i, input int k);
      return 48'((i + 1) * 4096 + k + 16);
   endfunction

   int lat, t0, d0, e0;

   initial begin
      reset_dut();

      // Single two-byte message.
      t0 = trig_cnt;
      set_req(1, 3'b010, 4'd0, 48'h0000_0000_A55A);
      wait_trig("t1", lat);
      check("t1_latency", lat, 1);
      check("t1_data", spi_output_data, 48'h0000_0000_A55A);
      check("t1_type", spi_msg_type, 3'b010);
      check("t1_count", spi_byte_count, 0);
      serve(1, "t1");
      req[1] = 0;
      tick(); tick();
      check("t1_one_trigger", trig_cnt - t0, 1);

      // Two requesters, three messages each, strict alternation.
      reset_dut();
      set_req(0, 3'b010, 4'd0, pay(0, 0));
      set_req(2, 3'b010, 4'd0, pay(2, 0));
      for (int n = 0; n < 6; n++) begin
         int e;
         e = (n % 2 == 0) ? 0 : 2;
         wait_trig("rr", lat);
         check("rr_data", spi_output_data, pay(e, n / 2));
         serve(e, "rr");
         if (n / 2 == 2) req[e] = 0;
         else req_data[48*e +: 48] = pay(e, n / 2 + 1);
      end

      // Receive pre-empts a send; same payload retried, one done.
      reset_dut();
      t0 = trig_cnt; d0 = n_done;
      set_req(3, 3'b001, 4'd0, 48'h0000_0000_003C);
      wait_trig("pre", lat);
      tick(); spi_busy = 1;
      tick(); tick();
      spi_received = 1; spi_received_data = 48'h0000_0000_1234; spi_busy = 0;
      tick(); spi_received = 0;
      wait_trig("pre2", lat);
      check("pre_retry_lat", lat, 0);
      check("pre_data", spi_output_data, 48'h0000_0000_003C);
      serve(3, "pre");
      req[3] = 0;
      repeat (3) tick();
      check("pre_triggers", trig_cnt - t0, 2);
      check("pre_dones", n_done - d0, 1);

      // Long header arrives in the same cycle as a long request: arming wins.
      reset_dut();
      t0 = trig_cnt;
      set_req(0, 3'b111, 4'd5, 48'h0011_2233_4455);
      spi_received = 1; spi_received_data = 48'h0000_0000_F004;
      tick(); spi_received = 0;
      check("arm_long_coming", spi_long_coming, 1);
      check("arm_count", spi_byte_count, 4);
      check("arm_rx_long", rx_long, 0);
      repeat (4) begin
         check("arm_no_trigger", spi_send_trigger, 0);
         tick();
      end
      spi_received = 1; spi_received_data = 48'h0000_0000_0055;
      tick(); spi_received = 0;
      check("disarm_rx_long", rx_long, 1);
      check("disarm_long_coming", spi_long_coming, 0);
      check("arm_blocked_triggers", trig_cnt - t0, 0);
      wait_trig("long", lat);
      check("long_latency", lat, 1);
      check("long_count", spi_byte_count, 5);
      check("long_data", spi_output_data, 48'h0011_2233_4455);
      serve(0, "long");
      req[0] = 0;
      tick();

      // Rejects, pointer advance past rejected requesters.
      reset_dut();
      t0 = trig_cnt; e0 = n_errp;
      set_req(1, 3'b111, 4'd7, 48'h1);
      tick();
      check("rej_len7", err, 4'b0010);
      req[1] = 0;
      set_req(0, 3'b111, 4'd0, 48'h2);
      tick();
      check("rej_len0", err, 4'b0001);
      req[0] = 0;
      set_req(2, 3'b000, 4'd0, 48'h3);
      tick();
      check("rej_type0", err, 4'b0100);
      req[2] = 0;
      tick();
      check("rej_no_trigger", trig_cnt - t0, 0);
      check("rej_err_count", n_errp - e0, 3);
      set_req(0, 3'b001, 4'd0, 48'h0000_0000_00D0);
      set_req(3, 3'b001, 4'd0, 48'h0000_0000_00D3);
      wait_trig("ptr3", lat);
      check("ptr_first_3", spi_output_data, 48'h0000_0000_00D3);
      serve(3, "ptr3");
      req[3] = 0;
      wait_trig("ptr0", lat);
      check("ptr_then_0", spi_output_data, 48'h0000_0000_00D0);
      serve(0, "ptr0");
      req[0] = 0;

      // Engine never reports sent: error 15 cycles after entering WAIT_SENT.
      reset_dut();
      d0 = n_done;
      set_req(2, 3'b011, 4'd0, 48'h0000_00AB_CDEF);
      wait_trig("tmo", lat);
      tick(); spi_busy = 1;
      tick();
      lat = 0;
      while (err == '0 && lat < 40) begin
         tick();
         lat++;
      end
      check("tmo_latency", lat, 15);
      check("tmo_err", err, 4'b0100);
      spi_busy = 0; req[2] = 0;
      tick();
      check("tmo_no_done", n_done - d0, 0);

      // Reset in the middle of WAIT_SENT: outputs clear, aborted request silent.
      reset_dut();
      set_req(1, 3'b001, 4'd0, 48'h0000_0000_0077);
      wait_trig("rst", lat);
      tick(); spi_busy = 1;
      tick(); tick();
      d0 = n_done; e0 = n_errp;
      RST = 1;
      #1;
      check("rst_async_zero", outs_nonzero(), 0);
      tick();
      check("rst_edge_zero", outs_nonzero(), 0);
      req = '0; spi_busy = 0;
      RST = 0;
      repeat (6) tick();
      check("rst_no_done", n_done - d0, 0);
      check("rst_no_err", n_errp - e0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/spi_msg_sched.md
# spi_msg_sched

Message scheduler in front of the SPI slave engine. Arbitrates up to `N_REQ` internal requesters (round-robin) for the single outgoing SPI channel. Drives the engine's send handshake, holds payload stable for the whole transfer, and retries sends pre-empted by a master-initiated receive. Decodes received headers to arm the engine for long incoming messages.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TMO_W`, 16: width of the send-timeout counter; timeout = 2^TMO_W−1 CLK cycles.
- `CLK` input 1: system clock.
- `RST` input 1: reset, asynchronous, active-high.
- `req` input N_REQ: request level per requester; held until `done`/`err` for that index.
- `req_type` input 3·N_REQ: message type per requester (000 none, 001 one byte, 010 two bytes, 011 three bytes, 110 six bytes, 111 long).
- `req_len` input 4·N_REQ: byte count for long type (1..6); ignored otherwise.
- `req_data` input 48·N_REQ: payload; MSB-aligned to bit (8·bytes−1).
- `done` output N_REQ: one-cycle pulse, message sent.
- `err` output N_REQ: one-cycle pulse, request rejected or timed out.
- `spi_send_trigger` output 1: to engine `send_trigger`.
- `spi_output_data` output 48: to engine `output_data`; registered.
- `spi_msg_type` output 3: to engine `SPI_MSG_TYPE`.
- `spi_byte_count` output 4: to engine `InMsgByteCount`.
- `spi_long_coming` output 1: to engine `LongMsgComing`.
- `spi_busy`, `spi_sent`, `spi_received` input 1: from engine.
- `spi_received_data` input 48: from engine.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated.
- `rx_data` output 48: last received word.
- `rx_long` output 1: `rx_data` came from a long (armed) receive.

## Operation
- FSM states: IDLE, TRIG, WAIT_BUSY, WAIT_SENT, DONE.
- **IDLE:** if any eligible `req`, grant the lowest index at or after `rr_ptr`. Eligible means:
  - type ≠ 000;
  - not (type 111 while long receive armed);
  - long `req_len` in 1..6.
- **IDLE rejects:** type 000, or a long request with `req_len` 0 or >6, is not granted. It gets an `err` pulse instead, and `rr_ptr` advances past it.
- **Grant:** latch data, type and index into `spi_output_data` / `spi_msg_type` / `gnt_idx`; go to TRIG.
- **TRIG:** if `spi_busy`=0, assert `spi_send_trigger` for exactly one cycle, go to WAIT_BUSY. Otherwise stay.
- **WAIT_BUSY:**
  - `spi_busy`=1 → WAIT_SENT.
  - `spi_busy`=0 for 2 cycles (trigger lost) → TRIG.
- **WAIT_SENT:**
  - `spi_sent` → DONE.
  - `spi_received` (engine took a receive instead) → TRIG; retry with same latched payload.
  - Timeout counter reaching all-ones → `err[gnt_idx]` pulse, go to IDLE.
  - Counter clears on entering WAIT_SENT.
- **DONE:** pulse `done[gnt_idx]`, set `rr_ptr`=`gnt_idx`+1 mod N_REQ, go to IDLE.
- `spi_output_data` / `spi_msg_type` change only on grant; held through DONE.
- **Receive path (independent of FSM):**
  - On `spi_received`: `rx_data`←`spi_received_data`, `rx_long`←`long_armed`, `rx_valid` pulse next cycle.
  - If not armed and `spi_received_data[15:12]`=4'hF and `[3:0]` in 1..6: set `long_armed`, `long_len`←`[3:0]`.
  - Any `spi_received` while armed clears `long_armed`.
- **Engine outputs:**
  - `spi_long_coming`=`long_armed`.
  - `spi_byte_count`=`long_armed` ? `long_len` : latched `req_len` of granted request (0 when none).

## Timing
- Reset: all outputs 0, `rr_ptr`=0, `long_armed`=0, FSM IDLE, counters 0.
- Grant: 1 cycle after `req` seen in IDLE. `spi_send_trigger` earliest on the following cycle.
- `done` pulse: 1 cycle after `spi_sent` pulse. `err` pulse: 1 cycle after reject/timeout detection.
- Deasserted `req` ignored after grant; latched message completes.
- `spi_sent` and `spi_received` in the same cycle: both handled, sent wins for FSM.
- Arming and a grant in the same cycle: arming wins; a type-111 grant is suppressed that cycle.
- RST mid-transfer: immediate return to reset values. No `done`/`err` emitted for the aborted request.

## Structure
- Shared package `spi_pkg`:
  - msg-type constants (NO_BY, ONE_BY, STD_TWO_BY, THREE_BY, SIX_BY, LONG);
  - long-header code 4'hF;
  - max long length 6.
- One sub-module, `rr_arbiter`: N_REQ-wide round-robin pick from eligibility mask and pointer; combinational grant + valid.

## Test plan
- Single req[1], type 010, data 48'h0000_0000_A55A; engine `spi_busy`=1 one cycle after trigger, `spi_sent` later → one trigger pulse, `spi_output_data`=..A55A stable until `done[1]`.
- req[0] and req[2] both held, each 3 messages → grants alternate 0,2,0,2,0,2.
- `spi_received` pulse during WAIT_SENT → second trigger issued with identical data; exactly one `done`.
- Received word 16'hF004 → `spi_long_coming`=1, `spi_byte_count`=4. Long req blocked until next `spi_received`, which sets `rx_long`=1 and clears arming.
- Long req with `req_len`=0 → `err` pulse, no trigger. Type 000 → `err`.
- TMO_W=4, engine never pulses `spi_sent` → `err` 15 cycles after WAIT_SENT entry. RST asserted mid-WAIT_SENT → all outputs 0 next edge.
